// File: rtl/brimstone_rf_pkg.sv
// Shared register-file constants: geometry, the hard-wired zero register and writeback requester indices.
package brimstone_rf_pkg;

   localparam int RF_ADDR_WIDTH = 5;
   localparam int RF_DATA_WIDTH = 32;
   localparam int RF_ZERO_ADDR  = 0;

   localparam int WB_REQ_ALU = 0;
   localparam int WB_REQ_LSU = 1;

endpackage

// File: rtl/rr_grant.sv
// Combinational one-hot round-robin picker: grants the first valid requester
// at or after ptr_i, searching upward modulo N_P.
module rr_grant #(
   parameter int N_P     = 2,
   parameter int PTR_W_P = 1
) (
   input  logic [N_P-1:0]     valid_i,
   input  logic [PTR_W_P-1:0] ptr_i,
   output logic [N_P-1:0]     grant_o
);

   int  idx;
   logic found;

   always_comb begin
      grant_o = '0;
      found   = 1'b0;
      idx     = 0;
      for (int off = 0; off < N_P; off++) begin
         idx = int'(ptr_i) + off;
         if (idx >= N_P) idx = idx - N_P;
         if (!found && valid_i[idx]) begin
            grant_o[idx] = 1'b1;
            found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: one registered write per cycle from NUM_REQ_P writeback sources.
// Define REGFILE_WB_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module regfile_wb_arbiter
   import brimstone_rf_pkg::*;
#(
   parameter int NUM_REQ_P    = 2,
   parameter int DATA_WIDTH_P = RF_DATA_WIDTH,
   parameter int ADDR_WIDTH_P = RF_ADDR_WIDTH,
   parameter int CNT_WIDTH_P  = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_REQ_P-1:0]             i_req_valid,
   input  logic [NUM_REQ_P*ADDR_WIDTH_P-1:0] i_req_addr,
   input  logic [NUM_REQ_P*DATA_WIDTH_P-1:0] i_req_data,
   output logic [NUM_REQ_P-1:0]             o_req_ready,
   input  logic                             i_hold,
   output logic                             o_wr_enable,
   output logic [ADDR_WIDTH_P-1:0]          o_wr_addr,
   output logic [DATA_WIDTH_P-1:0]          o_wr_data,
   output logic                             o_rd_block,
   output logic [CNT_WIDTH_P-1:0]           o_conflict_cnt
);

   localparam int PTR_W = (NUM_REQ_P > 1) ? $clog2(NUM_REQ_P) : 1;

   logic [PTR_W-1:0]        ptr;
   logic [NUM_REQ_P-1:0]    gnt_raw;
   logic [NUM_REQ_P-1:0]    gnt;
   logic                    accept;
   logic                    multi_valid;
   logic [ADDR_WIDTH_P-1:0] sel_addr;
   logic [DATA_WIDTH_P-1:0] sel_data;
   logic                    wr_en_q;
   logic [ADDR_WIDTH_P-1:0] wr_addr_q;
   logic [DATA_WIDTH_P-1:0] wr_data_q;
   logic [CNT_WIDTH_P-1:0]  cnt_q;

   rr_grant #(
      .N_P     (NUM_REQ_P),
      .PTR_W_P (PTR_W)
   ) u_rr_grant (
      .valid_i (i_req_valid),
      .ptr_i   (ptr),
      .grant_o (gnt_raw)
   );

   // Reset also masks the grant so nothing is accepted while the output register clears.
   assign gnt         = (reset || i_hold) ? '0 : gnt_raw;
   assign o_req_ready = gnt;
   assign accept      = |gnt;
   assign multi_valid = |(i_req_valid & (i_req_valid - NUM_REQ_P'(1)));

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int k = 0; k < NUM_REQ_P; k++) begin
         if (gnt[k]) begin
            sel_addr = i_req_addr[k*ADDR_WIDTH_P +: ADDR_WIDTH_P];
            sel_data = i_req_data[k*DATA_WIDTH_P +: DATA_WIDTH_P];
         end
      end
   end

`ifdef REGFILE_WB_ARB_FIXED_PRIO_EN
   assign ptr = '0;
`else
   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      for (int k = 0; k < NUM_REQ_P; k++) begin
         if (gnt[k]) ptr_d = (k == NUM_REQ_P-1) ? '0 : PTR_W'(k+1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;
`endif

   // x0 writes are accepted but dropped; addr/data keep the last real write.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         cnt_q     <= '0;
      end else begin
         wr_en_q <= accept && (sel_addr != ADDR_WIDTH_P'(RF_ZERO_ADDR));
         if (accept && (sel_addr != ADDR_WIDTH_P'(RF_ZERO_ADDR))) begin
            wr_addr_q <= sel_addr;
            wr_data_q <= sel_data;
         end
         if (multi_valid && !i_hold && (cnt_q != '1)) cnt_q <= cnt_q + CNT_WIDTH_P'(1);
      end
   end

   assign o_wr_enable    = wr_en_q;
   assign o_rd_block     = wr_en_q;
   assign o_wr_addr      = wr_addr_q;
   assign o_wr_data      = wr_data_q;
   assign o_conflict_cnt = cnt_q;

endmodule
